// File: rtl/bf_program_loader.sv
// Brainfuck program loader: filters ASCII source, encodes commands into 3-bit opcodes,
// writes them to sequential command-memory addresses and checks bracket balance.
module bf_program_loader #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DEPTH_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_trigger,
    input  logic                  i_start,
    input  logic                  i_in_valid,
    input  logic [7:0]            i_in_data,
    output logic                  o_in_ready,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [2:0]            o_mem_data,
    output logic [ADDR_WIDTH-1:0] o_prog_len,
    output logic                  o_run_enable,
    output logic                  o_busy,
    output logic                  o_error,
    output logic [1:0]            o_error_code
);

    localparam logic [2:0] OP_INC   = 3'b000;
    localparam logic [2:0] OP_DEC   = 3'b001;
    localparam logic [2:0] OP_OPEN  = 3'b010;
    localparam logic [2:0] OP_CLOSE = 3'b011;
    localparam logic [2:0] OP_RIGHT = 3'b100;
    localparam logic [2:0] OP_LEFT  = 3'b101;
    localparam logic [2:0] OP_OUT   = 3'b110;
    localparam logic [2:0] OP_IN    = 3'b111;

    localparam logic [1:0] ERR_UNMATCHED = 2'b00;
    localparam logic [1:0] ERR_UNCLOSED  = 2'b01;
    localparam logic [1:0] ERR_DEPTH     = 2'b10;
    localparam logic [1:0] ERR_TOO_LONG  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ADDR_WIDTH-1:0]  r_wr_ptr;
    logic [DEPTH_WIDTH-1:0] r_depth;
    logic [1:0]             r_err_code;
    logic [ADDR_WIDTH-1:0]  r_prog_len;
    logic                   r_mem_we;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [2:0]             r_mem_data;

    logic [ADDR_WIDTH-1:0]  w_wr_ptr_nxt;
    logic [DEPTH_WIDTH-1:0] w_depth_nxt;
    logic [1:0]             w_err_code_nxt;
    logic [ADDR_WIDTH-1:0]  w_prog_len_nxt;
    logic                   w_mem_we_nxt;
    logic [ADDR_WIDTH-1:0]  w_mem_addr_nxt;
    logic [2:0]             w_mem_data_nxt;

    logic                   w_accept;
    logic                   w_is_term;
    logic                   w_is_cmd;
    logic [2:0]             w_opcode;
    logic                   w_full;
    logic                   w_depth_zero;
    logic                   w_depth_max;
    logic                   w_cmd_err;
    logic [1:0]             w_cmd_err_code;

    assign w_accept     = i_in_valid && (r_state == S_LOAD);
    assign w_is_term    = (i_in_data == 8'h00);
    assign w_full       = (r_wr_ptr == {ADDR_WIDTH{1'b1}});
    assign w_depth_zero = (r_depth == '0);
    assign w_depth_max  = (r_depth == {DEPTH_WIDTH{1'b1}});

    // ASCII to opcode; anything not listed is a comment character
    always_comb begin
        w_is_cmd = 1'b1;
        w_opcode = OP_INC;
        case (i_in_data)
            8'h2B:   w_opcode = OP_INC;
            8'h2D:   w_opcode = OP_DEC;
            8'h5B:   w_opcode = OP_OPEN;
            8'h5D:   w_opcode = OP_CLOSE;
            8'h3E:   w_opcode = OP_RIGHT;
            8'h3C:   w_opcode = OP_LEFT;
            8'h2E:   w_opcode = OP_OUT;
            8'h2C:   w_opcode = OP_IN;
            default: w_is_cmd = 1'b0;
        endcase
    end

    // Command-level faults; a full memory wins over bracket faults
    always_comb begin
        w_cmd_err      = 1'b0;
        w_cmd_err_code = ERR_UNMATCHED;
        if (w_full) begin
            w_cmd_err      = 1'b1;
            w_cmd_err_code = ERR_TOO_LONG;
        end else if ((w_opcode == OP_OPEN) && w_depth_max) begin
            w_cmd_err      = 1'b1;
            w_cmd_err_code = ERR_DEPTH;
        end else if ((w_opcode == OP_CLOSE) && w_depth_zero) begin
            w_cmd_err      = 1'b1;
            w_cmd_err_code = ERR_UNMATCHED;
        end
    end

    always_ff @(posedge clk or posedge reset_trigger) begin
        if (reset_trigger) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    if (w_is_term) begin
                        w_state_nxt = w_depth_zero ? S_DONE : S_ERROR;
                    end else if (w_is_cmd && w_cmd_err) begin
                        w_state_nxt = S_ERROR;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath updates driven by the current state and the accepted byte
    always_comb begin
        w_wr_ptr_nxt   = r_wr_ptr;
        w_depth_nxt    = r_depth;
        w_err_code_nxt = r_err_code;
        w_prog_len_nxt = r_prog_len;
        w_mem_we_nxt   = 1'b0;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_data_nxt = r_mem_data;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    w_wr_ptr_nxt   = '0;
                    w_depth_nxt    = '0;
                    w_err_code_nxt = ERR_UNMATCHED;
                    w_prog_len_nxt = '0;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    if (w_is_term) begin
                        if (w_depth_zero) begin
                            w_prog_len_nxt = r_wr_ptr;
                        end else begin
                            w_err_code_nxt = ERR_UNCLOSED;
                        end
                    end else if (w_is_cmd) begin
                        if (w_cmd_err) begin
                            w_err_code_nxt = w_cmd_err_code;
                        end else begin
                            w_mem_we_nxt   = 1'b1;
                            w_mem_addr_nxt = r_wr_ptr;
                            w_mem_data_nxt = w_opcode;
                            w_wr_ptr_nxt   = r_wr_ptr + ADDR_WIDTH'(1);
                            if (w_opcode == OP_OPEN) begin
                                w_depth_nxt = r_depth + DEPTH_WIDTH'(1);
                            end else if (w_opcode == OP_CLOSE) begin
                                w_depth_nxt = r_depth - DEPTH_WIDTH'(1);
                            end
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset_trigger) begin
        if (reset_trigger) begin
            r_wr_ptr   <= '0;
            r_depth    <= '0;
            r_err_code <= '0;
            r_prog_len <= '0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_depth    <= w_depth_nxt;
            r_err_code <= w_err_code_nxt;
            r_prog_len <= w_prog_len_nxt;
            r_mem_we   <= w_mem_we_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_data <= w_mem_data_nxt;
        end
    end

    // Status flags decode straight from the state register
    assign o_in_ready   = (r_state == S_LOAD);
    assign o_busy       = (r_state == S_LOAD);
    assign o_run_enable = (r_state == S_DONE);
    assign o_error      = (r_state == S_ERROR);
    assign o_error_code = r_err_code;
    assign o_prog_len   = r_prog_len;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_data   = r_mem_data;

endmodule

// File: tb/tb_bf_program_loader.sv
// Scoreboard bench for bf_program_loader: a sequential source-text model predicts
// writes and final status; a monitor compares them against the DUT outputs.
module tb_bf_program_loader;

    localparam int unsigned AW   = 4;
    localparam int unsigned DW   = 2;
    localparam int          CAP  = (1 << AW) - 1;
    localparam int          DMAX = (1 << DW) - 1;

    logic          clk;
    logic          reset_trigger;
    logic          i_start;
    logic          i_in_valid;
    logic [7:0]    i_in_data;
    logic          o_in_ready;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [2:0]    o_mem_data;
    logic [AW-1:0] o_prog_len;
    logic          o_run_enable;
    logic          o_busy;
    logic          o_error;
    logic [1:0]    o_error_code;

    bf_program_loader #(.ADDR_WIDTH(AW), .DEPTH_WIDTH(DW)) dut (
        .clk          (clk),
        .reset_trigger(reset_trigger),
        .i_start      (i_start),
        .i_in_valid   (i_in_valid),
        .i_in_data    (i_in_data),
        .o_in_ready   (o_in_ready),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data),
        .o_prog_len   (o_prog_len),
        .o_run_enable (o_run_enable),
        .o_busy       (o_busy),
        .o_error      (o_error),
        .o_error_code (o_error_code)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [2:0]    data;
    } wr_t;

    typedef struct {
        bit            is_err;
        logic [1:0]    code;
        logic [AW-1:0] len;
    } res_t;

    wr_t        exp_wr_q[$];
    res_t       exp_res_q[$];
    logic [7:0] prog_q[$];
    int         total = 0;
    int         bad = 0;
    int         n_res_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: walk the text once, stop at terminator or first fault
    task automatic model_prog(output int consumed);
        string cmds = "+-[]><.,";
        int    ptr = 0;
        int    dep = 0;
        int    op;
        res_t  r;
        wr_t   w;
        r.is_err = 1'b0;
        r.code   = 2'd0;
        r.len    = '0;
        consumed = prog_q.size();
        for (int i = 0; i < prog_q.size(); i++) begin
            if (prog_q[i] == 8'h00) begin
                consumed = i + 1;
                if (dep == 0) r.len = AW'(ptr);
                else begin r.is_err = 1'b1; r.code = 2'd1; end
                exp_res_q.push_back(r);
                return;
            end
            op = -1;
            for (int k = 0; k < 8; k++) if (prog_q[i] == cmds[k]) op = k;
            if (op < 0) continue;
            if (ptr == CAP)                 begin r.is_err = 1'b1; r.code = 2'd3; end
            else if (op == 2 && dep == DMAX) begin r.is_err = 1'b1; r.code = 2'd2; end
            else if (op == 3 && dep == 0)    begin r.is_err = 1'b1; r.code = 2'd0; end
            if (r.is_err) begin
                consumed = i + 1;
                exp_res_q.push_back(r);
                return;
            end
            w.addr = AW'(ptr);
            w.data = 3'(op);
            exp_wr_q.push_back(w);
            ptr++;
            if (op == 2) dep++;
            if (op == 3) dep--;
        end
    endtask

    task automatic load_str(input string s, input bit term);
        prog_q = {};
        for (int i = 0; i < s.len(); i++) prog_q.push_back(s[i]);
        if (term) prog_q.push_back(8'h00);
    endtask

    // mode: 0 = valid held high, 1 = random bubbles, 2 = valid every other cycle
    task automatic run_prog(input int mode);
        int consumed;
        int idx = 0;
        int cyc = 0;
        int res_before;
        bit acc;
        model_prog(consumed);
        res_before = n_res_seen;
        @(negedge clk);
        i_start    = 1'b1;
        i_in_valid = 1'b1;
        i_in_data  = prog_q[0];
        @(negedge clk);
        i_start = 1'b0;
        while (idx < consumed && cyc < 2000) begin
            case (mode)
                0:       i_in_valid = 1'b1;
                1:       i_in_valid = 1'($urandom_range(0, 1));
                default: i_in_valid = (cyc % 2 == 0);
            endcase
            i_start   = ($urandom_range(0, 7) == 0);
            i_in_data = prog_q[idx];
            acc       = i_in_valid && o_in_ready;
            @(negedge clk);
            cyc++;
            if (acc) idx++;
        end
        i_start    = 1'b0;
        i_in_valid = 1'b0;
        chk("load_complete", idx, consumed);
        chk("ready_low_after_end", o_in_ready, 1'b0);
        chk("status_next_cycle", o_run_enable | o_error, 1'b1);
        repeat (2) @(negedge clk);
        chk("result_observed", n_res_seen, res_before + 1);
    endtask

    task automatic gen_random();
        string plain = "+-><.,";
        int    n = $urandom_range(0, 20);
        bit    bal = 1'($urandom_range(0, 1));
        int    dep = 0;
        int    k;
        prog_q = {};
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 11);
            if (k <= 5) prog_q.push_back(plain[k]);
            else if (k <= 7) begin
                if (bal && dep == DMAX) prog_q.push_back(8'h2B);
                else begin prog_q.push_back(8'h5B); dep++; end
            end else if (k <= 9) begin
                if (bal && dep == 0) prog_q.push_back(8'h2D);
                else begin prog_q.push_back(8'h5D); if (dep > 0) dep--; end
            end else if (k == 10) prog_q.push_back(8'($urandom_range(8'h61, 8'h7A)));
            else prog_q.push_back(8'($urandom_range(1, 255)));
        end
        if (bal) for (int i = 0; i < dep; i++) prog_q.push_back(8'h5D);
        prog_q.push_back(8'h00);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, o_in_ready, 1'b0);
        chk({tag, "_mem_we"}, o_mem_we, 1'b0);
        chk({tag, "_mem_addr"}, o_mem_addr, '0);
        chk({tag, "_mem_data"}, o_mem_data, '0);
        chk({tag, "_prog_len"}, o_prog_len, '0);
        chk({tag, "_run_enable"}, o_run_enable, 1'b0);
        chk({tag, "_busy"}, o_busy, 1'b0);
        chk({tag, "_error"}, o_error, 1'b0);
        chk({tag, "_error_code"}, o_error_code, 2'd0);
    endtask

    // Monitor: pops expected writes on each strobe and expected status on completion
    initial begin : monitor
        bit   prev_end = 1'b0;
        bit   cur_end;
        wr_t  w;
        res_t r;
        forever begin
            @(negedge clk);
            if (reset_trigger) begin
                prev_end = 1'b0;
                continue;
            end
            chk("flags_exclusive", 32'($countones({o_busy, o_run_enable, o_error}) <= 1), 1);
            if (o_mem_we) begin
                if (exp_wr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr=%0h data=%0b, none expected", o_mem_addr, o_mem_data);
                end else begin
                    w = exp_wr_q.pop_front();
                    chk("wr_addr", o_mem_addr, w.addr);
                    chk("wr_data", o_mem_data, w.data);
                end
            end
            cur_end = o_run_enable | o_error;
            if (cur_end && !prev_end) begin
                if (exp_res_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_status: run=%0b err=%0b, none expected", o_run_enable, o_error);
                end else begin
                    r = exp_res_q.pop_front();
                    chk("writes_before_status", exp_wr_q.size(), 0);
                    chk("res_error", o_error, r.is_err);
                    chk("res_run_enable", o_run_enable, !r.is_err);
                    chk("res_error_code", o_error_code, r.code);
                    if (!r.is_err) chk("res_prog_len", o_prog_len, r.len);
                end
                n_res_seen++;
            end
            prev_end = cur_end;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        wr_t w;
        reset_trigger = 1'b1;
        i_start       = 1'b0;
        i_in_valid    = 1'b0;
        i_in_data     = 8'h00;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset_trigger = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("idle");

        load_str("+[->+<]", 1'b1);
        run_prog(0);
        chk("t1_prog_len", o_prog_len, 7);

        load_str("a+ b\n-.,", 1'b1);
        run_prog(2);
        chk("t2_prog_len", o_prog_len, 4);

        load_str("]", 1'b0);
        run_prog(0);
        chk("t3_error_code", o_error_code, 2'd0);
        load_str("+", 1'b1);
        run_prog(1);
        chk("t3_error_cleared", o_error, 1'b0);
        chk("t3_prog_len", o_prog_len, 1);

        load_str("[[]", 1'b1);
        run_prog(1);
        chk("t4_error_code", o_error_code, 2'd1);
        chk("t4_run_enable", o_run_enable, 1'b0);

        load_str("[[[[", 1'b0);
        run_prog(0);
        chk("t5_error_code", o_error_code, 2'd2);

        load_str("++++++++++++++++", 1'b0);
        run_prog(1);
        chk("t6_error_code", o_error_code, 2'd3);

        // Reset after the third accepted '>' drops its in-flight strobe
        for (int i = 0; i < 2; i++) begin
            w.addr = AW'(i);
            w.data = 3'b100;
            exp_wr_q.push_back(w);
        end
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start    = 1'b0;
        i_in_valid = 1'b1;
        i_in_data  = 8'h3E;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset_trigger = 1'b1;
        i_in_valid = 1'b0;
        #1 chk_all_zero("async_reset");
        @(posedge clk);
        #2 reset_trigger = 1'b0;
        @(negedge clk);
        chk_all_zero("post_reset");
        chk("reset_writes_flushed", exp_wr_q.size(), 0);

        load_str(">", 1'b1);
        run_prog(0);
        chk("t7_prog_len", o_prog_len, 1);

        for (int n = 0; n < 60; n++) begin
            gen_random();
            run_prog(n % 3);
        end

        repeat (4) @(negedge clk);
        chk("final_wr_q_empty", exp_wr_q.size(), 0);
        chk("final_res_q_empty", exp_res_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bf_program_loader.md
# bf_program_loader

Upstream stage of the Brainfuck core. It accepts BF source text as an ASCII byte stream over a valid/ready handshake and drops every non-command character. Each command is encoded into the 3-bit opcode format used by the command memory and written to sequential addresses. While loading it checks bracket balance; it asserts `run_enable`, which feeds the command runner's `run_trigger`, only after a complete, well-formed program has been stored.

## Interface
- `ADDR_WIDTH`, default 16: command memory address width.
- `DEPTH_WIDTH`, default 8: bracket nesting counter width. Maximum depth is 2^DEPTH_WIDTH-1.
- `clk`  in  1  clock.
- `reset_trigger`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle pulse that begins a (re)load.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  8  ASCII source byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  command memory write strobe.
- `mem_addr`  out  ADDR_WIDTH  command memory write address.
- `mem_data`  out  3  encoded opcode.
- `prog_len`  out  ADDR_WIDTH  number of stored commands. Valid in DONE.
- `run_enable`  out  1  program loaded and valid. Drives the runner's `run_trigger`.
- `busy`  out  1  high in LOAD.
- `error`  out  1  high in ERROR.
- `error_code`  out  2  error cause: 00 unmatched `]`, 01 unclosed `[`, 10 depth overflow, 11 program too long.

## Operation
- States are IDLE, LOAD, DONE and ERROR. Reset state is IDLE.
- A byte is accepted on a rising edge when `in_valid & in_ready`.
- `in_ready` is 1 only in LOAD.
- Encoding (ASCII value → opcode):
  - `+` (0x2B) → 000
  - `-` (0x2D) → 001
  - `[` (0x5B) → 010
  - `]` (0x5D) → 011
  - `>` (0x3E) → 100
  - `<` (0x3C) → 101
  - `.` (0x2E) → 110
  - `,` (0x2C) → 111
- Any other byte except 0x00 is consumed and ignored: no write, write pointer unchanged.
- 0x00 is the end-of-program terminator.
- Accepted command: write opcode at `wr_ptr`, then `wr_ptr += 1`.
  - `[`: `depth += 1`.
  - `]`: `depth -= 1`.
- Transitions:
  - IDLE + `start` → LOAD. `wr_ptr`, `depth` and `error_code` are cleared.
  - LOAD + terminator with `depth == 0` → DONE, `prog_len <= wr_ptr`.
  - LOAD + terminator with `depth != 0` → ERROR, code 01.
  - LOAD + `]` with `depth == 0` → ERROR, code 00. No write.
  - LOAD + `[` with `depth == 2^DEPTH_WIDTH-1` → ERROR, code 10. No write.
  - LOAD + any command with `wr_ptr == 2^ADDR_WIDTH-1` → ERROR, code 11. No write. Capacity is 2^ADDR_WIDTH-1 commands, so `wr_ptr` never wraps.
  - DONE or ERROR + `start` → LOAD. `run_enable` and `error` drop, counters are cleared.
  - `start` in LOAD is ignored.
- An empty program (terminator first) goes to DONE with `prog_len = 0`.
- `run_enable` is 1 only in DONE.
- `error`/`error_code` hold until the next `start` or reset.
- Memory contents are never cleared by this block. A partial program remains after an error or a reset.

## Timing
- Reset values: every output is 0, including `in_ready`, `mem_we`, `mem_addr`, `mem_data`, `prog_len`, `run_enable`, `busy`, `error` and `error_code`.
- Reset mid-LOAD aborts immediately to IDLE with all outputs 0. A write strobe in flight is dropped.
- `mem_we`, `mem_addr` and `mem_data` are registered. `mem_we` is high for exactly the one cycle after each accepted command byte.
- Throughput is 1 byte per cycle with `in_valid` held high. Bubbles in `in_valid` are tolerated with no lost or duplicated bytes.
- Terminator accepted at edge N:
  - DONE/`run_enable` from cycle N+1.
  - The last command write strobe is at or before cycle N, so memory is complete before the runner starts.
- The error state is entered on the edge that accepts the offending byte, so `in_ready` is 0 from the next cycle.
- `start` in IDLE/DONE/ERROR takes effect on the next edge. `in_ready` rises one cycle after `start`. A byte presented during the `start` cycle is not accepted.
- `busy`, `run_enable` and `error` decode directly from the state register and are mutually exclusive.

## Test plan
- `start`, then `+[->+<]` followed by 0x00 → 7 writes at addr 0..6 with data 000, 010, 001, 100, 000, 101, 011. `prog_len = 7`; `run_enable = 1` one cycle after the terminator is accepted; `error = 0`.
- `a+ b\n-.,` followed by 0x00, with `in_valid` toggled every other cycle → 4 writes (000, 001, 110, 111) at addr 0..3, no duplicates, `prog_len = 4`.
- `]` as the first byte → ERROR, `error_code = 00`, `mem_we` never asserted. A new `start` clears `error`, and `+` 0x00 then loads with `prog_len = 1`.
- `[[]` followed by 0x00 → ERROR, `error_code = 01`, `run_enable` stays 0. With DEPTH_WIDTH=2, `[[[[` → ERROR, code 10, on the 4th `[`, after exactly 3 writes.
- With ADDR_WIDTH=3, eight `+` bytes → 7 writes at addr 0..6, then ERROR with code 11 on the 8th.
- `reset_trigger` pulsed after 3 accepted commands → all outputs 0 asynchronously, state IDLE. A following `start` with `>` 0x00 writes addr 0 with data 100, `prog_len = 1`.
